// File: rtl/esti_pkg.sv
// esti_pkg
// Shared definitions for the ESTI sample front end.
//   state_e        : top-level operating mode (RUN or offset calibration)
//   DEF_*          : default values for the front-end parameters
package esti_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CAL = 1'b1
  } state_e;

  localparam int DEF_NUM_AXES = 3;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_CAL_LOG2 = 4;
  localparam int DEF_LED_AXIS = 0;

endpackage

// File: rtl/esti_axis_cal.sv
// esti_axis_cal
// Per-axis offset calibration and correction.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   acc_en_i : a good calibration frame is ending this cycle, accumulate raw_i
//   finish_i : with acc_en_i, this is the last calibration frame; load the offset
//   raw_i    : raw signed sample of this axis for the ending frame
//   corr_o   : raw_i - offset, saturated to the signed SAMPLE_W range
module esti_axis_cal
  import esti_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int CAL_LOG2 = DEF_CAL_LOG2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                acc_en_i,
  input  logic                finish_i,
  input  logic [SAMPLE_W-1:0] raw_i,
  output logic [SAMPLE_W-1:0] corr_o
);

  localparam int ACC_W = SAMPLE_W + CAL_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    acc_shift;
  logic [SAMPLE_W-1:0] off_q, off_d;
  logic [SAMPLE_W:0]   diff;

  // Accumulate sign-extended raw samples; on the last frame the running sum
  // (including that frame) is averaged into the offset and the accumulator
  // restarts from zero for the next calibration.
  always_comb begin
    acc_sum   = acc_q + {{CAL_LOG2{raw_i[SAMPLE_W-1]}}, raw_i};
    acc_shift = $signed(acc_sum) >>> CAL_LOG2;
    acc_d     = acc_q;
    off_d     = off_q;
    if (acc_en_i) begin
      if (finish_i) begin
        acc_d = '0;
        off_d = acc_shift[SAMPLE_W-1:0];
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      off_q <= '0;
    end else begin
      acc_q <= acc_d;
      off_q <= off_d;
    end
  end

  // One extra bit keeps the difference exact; if the top two bits disagree
  // the result left the SAMPLE_W range and is clamped to the nearest limit.
  always_comb begin
    diff = {raw_i[SAMPLE_W-1], raw_i} - {off_q[SAMPLE_W-1], off_q};
    if (diff[SAMPLE_W] != diff[SAMPLE_W-1]) begin
      corr_o = diff[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                              : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else begin
      corr_o = diff[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/esti_sample_frontend.sv
// esti_sample_frontend
// Assembles big-endian I2C byte bursts into multi-axis sensor frames,
// removes per-axis offsets learned during calibration and presents the
// corrected frame with a valid/ready handshake.
//   clk, reset          : clock and asynchronous active-low reset
//   byte_valid/byte_data: one received byte per cycle
//   frame_end           : burst complete (may coincide with the last byte)
//   cal_start           : start averaging 2^CAL_LOG2 good frames into offsets
//   sample_ready        : downstream accepts the presented frame
//   sample_valid/samples: corrected frame, axis 0 in the LSBs
//   frame_err           : pulse, a frame of the wrong length was discarded
//   cal_busy/cal_done   : calibration in progress / offsets just updated
//   overrun_cnt         : saturating count of overwritten unaccepted frames
//   led_out             : top byte of the corrected LED_AXIS sample
module esti_sample_frontend
  import esti_pkg::*;
#(
  parameter int NUM_AXES = DEF_NUM_AXES,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int CAL_LOG2 = DEF_CAL_LOG2,
  parameter int LED_AXIS = DEF_LED_AXIS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  input  logic                         frame_end,
  input  logic                         cal_start,
  input  logic                         sample_ready,
  output logic                         sample_valid,
  output logic [NUM_AXES*SAMPLE_W-1:0] samples,
  output logic                         frame_err,
  output logic                         cal_busy,
  output logic                         cal_done,
  output logic [7:0]                   overrun_cnt,
  output logic [7:0]                   led_out
);

  localparam int BPS         = SAMPLE_W / 8;
  localparam int FRAME_BYTES = NUM_AXES * BPS;
  localparam int FRAME_W     = NUM_AXES * SAMPLE_W;
  localparam int CNT_W       = $clog2(FRAME_BYTES + 2);

  localparam logic [CNT_W-1:0]    FULL_CNT   = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W-1:0]    EXCESS_CNT = CNT_W'(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CAL_LOG2-1:0] CAL_ONE    = CAL_LOG2'(1);

  logic [CNT_W-1:0]    cnt_q, cnt_eff;
  logic [FRAME_W-1:0]  bytes_q, bytes_eff;
  logic [FRAME_W-1:0]  raw_frame;
  logic [FRAME_W-1:0]  corr;
  logic                good_frame;
  logic                load;
  logic                acc_en;
  logic                cal_last;

  state_e              state_q;
  logic [CAL_LOG2-1:0] cal_cnt_q;
  logic                cal_done_q;
  logic                frame_err_q;
  logic [FRAME_W-1:0]  samples_q;
  logic                valid_q;
  logic [7:0]          ovr_q;

  // Byte position within the frame decides where it lands: byte 0 is the
  // most significant byte of the whole assembly vector. The counter
  // saturates one past a full frame so any excess is remembered without
  // wrapping back to a "correct" length. The byte arriving together with
  // frame_end is folded in here so the ending frame sees it.
  always_comb begin
    bytes_eff = bytes_q;
    cnt_eff   = cnt_q;
    if (byte_valid) begin
      if (cnt_q != EXCESS_CNT) begin
        cnt_eff = cnt_q + CNT_ONE;
      end
      for (int i = 0; i < FRAME_BYTES; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          bytes_eff[(FRAME_BYTES-1-i)*8 +: 8] = byte_data;
        end
      end
    end
  end

  assign good_frame = frame_end && (cnt_eff == FULL_CNT);
  assign load       = good_frame && (state_q == ST_RUN);
  assign acc_en     = good_frame && (state_q == ST_CAL);
  assign cal_last   = &cal_cnt_q;

  // Assembly state always restarts after frame_end, good or bad.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      bytes_q <= '0;
    end else if (frame_end) begin
      cnt_q   <= '0;
      bytes_q <= '0;
    end else begin
      cnt_q   <= cnt_eff;
      bytes_q <= bytes_eff;
    end
  end

  // Axis 0 arrived first, so it sits at the top of the byte vector but
  // belongs in the LSBs of the output word.
  for (genvar k = 0; k < NUM_AXES; k++) begin : g_axis
    assign raw_frame[k*SAMPLE_W +: SAMPLE_W] =
      bytes_eff[(NUM_AXES-1-k)*SAMPLE_W +: SAMPLE_W];

    esti_axis_cal #(
      .SAMPLE_W (SAMPLE_W),
      .CAL_LOG2 (CAL_LOG2)
    ) u_axis_cal (
      .clk_i    (clk),
      .rst_ni   (reset),
      .acc_en_i (acc_en),
      .finish_i (cal_last),
      .raw_i    (raw_frame[k*SAMPLE_W +: SAMPLE_W]),
      .corr_o   (corr[k*SAMPLE_W +: SAMPLE_W])
    );
  end

  // Mode control: calibration counts only good frames and hands back to
  // RUN on the same edge that loads the new offsets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cal_cnt_q   <= '0;
      cal_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_end && !good_frame;
      cal_done_q  <= 1'b0;
      case (state_q)
        ST_RUN: begin
          cal_cnt_q <= '0;
          if (cal_start) begin
            state_q <= ST_CAL;
          end
        end
        ST_CAL: begin
          if (good_frame) begin
            if (cal_last) begin
              state_q    <= ST_RUN;
              cal_cnt_q  <= '0;
              cal_done_q <= 1'b1;
            end else begin
              cal_cnt_q <= cal_cnt_q + CAL_ONE;
            end
          end
        end
        default: begin
          state_q   <= ST_RUN;
          cal_cnt_q <= '0;
        end
      endcase
    end
  end

  // Output handshake: a load always wins over an accept, and only counts
  // as an overrun when the previous frame was still waiting unaccepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samples_q <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= '0;
    end else if (load) begin
      samples_q <= corr;
      valid_q   <= 1'b1;
      if (valid_q && !sample_ready && (ovr_q != 8'hFF)) begin
        ovr_q <= ovr_q + 8'd1;
      end
    end else if (sample_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign sample_valid = valid_q;
  assign samples      = samples_q;
  assign frame_err    = frame_err_q;
  assign cal_busy     = (state_q == ST_CAL);
  assign cal_done     = cal_done_q;
  assign overrun_cnt  = ovr_q;
  assign led_out      = samples_q[LED_AXIS*SAMPLE_W + SAMPLE_W - 1 -: 8];

endmodule

// File: tb/tb_esti_sample_frontend.sv
// tb_esti_sample_frontend
// Bench for esti_sample_frontend at default parameters (3 axes x 16 bits,
// 16-frame calibration, LED on axis 0).
module tb_esti_sample_frontend;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        frame_end = 1'b0;
  logic        cal_start = 1'b0;
  logic        sample_ready = 1'b0;
  logic        sample_valid;
  logic [47:0] samples;
  logic        frame_err;
  logic        cal_busy;
  logic        cal_done;
  logic [7:0]  overrun_cnt;
  logic [7:0]  led_out;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    int          n;
    logic [63:0] data;
    bit          withEnd;
    bit          err;
    logic [47:0] samples;
    logic [7:0]  led;
  } vec_t;

  typedef struct {
    bit          err;
    logic [47:0] samples;
    logic [7:0]  led;
  } exp_t;

  vec_t vecs[9];
  exp_t sbQ[$];
  int   accModel[3];
  int   offModel[3];

  esti_sample_frontend dut (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .frame_end    (frame_end),
    .cal_start    (cal_start),
    .sample_ready (sample_ready),
    .sample_valid (sample_valid),
    .samples      (samples),
    .frame_err    (frame_err),
    .cal_busy     (cal_busy),
    .cal_done     (cal_done),
    .overrun_cnt  (overrun_cnt),
    .led_out      (led_out)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges the main sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      nPass++;
    end
  endtask

  function automatic logic [63:0] makeFrame(input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] a2);
    return {a0, a1, a2, 16'h0000};
  endfunction

  function automatic logic [15:0] corrModel(input logic [15:0] raw, input int off);
    int d;
    d = int'($signed(raw)) - off;
    if (d > 32767) d = 32767;
    else if (d < -32768) d = -32768;
    return d[15:0];
  endfunction

  // Drive n bytes (first byte in data[63:56]) then frame_end. withEnd puts
  // the last byte in the frame_end cycle; readyAtEnd raises sample_ready
  // only during the frame_end cycle. Returns on the negedge after the edge
  // that saw frame_end, where the frame's results are visible.
  task automatic applyStimulus(input int n, input logic [63:0] data, input bit withEnd,
                               input bit readyAtEnd);
    logic savedReady;
    int   nSep;
    savedReady = sample_ready;
    nSep = (withEnd && n > 0) ? n - 1 : n;
    for (int i = 0; i < nSep; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = data[63-8*i -: 8];
    end
    @(negedge clk);
    if (withEnd && n > 0) begin
      byte_valid = 1'b1;
      byte_data  = data[63-8*(n-1) -: 8];
    end else begin
      byte_valid = 1'b0;
    end
    frame_end = 1'b1;
    if (readyAtEnd) sample_ready = 1'b1;
    @(negedge clk);
    byte_valid   = 1'b0;
    frame_end    = 1'b0;
    sample_ready = savedReady;
  endtask

  task automatic expectFrame(input bit err, input logic [47:0] s);
    exp_t e;
    e.err     = err;
    e.samples = s;
    e.led     = s[15:8];
    sbQ.push_back(e);
  endtask

  // Wait (bounded) for the DUT to produce a result and compare it against
  // the oldest scoreboard entry.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   waitCnt;
    waitCnt = 0;
    while (!(sample_valid || frame_err) && waitCnt < 4) begin
      @(negedge clk);
      waitCnt++;
    end
    if (sbQ.size() == 0) begin
      nChecks++;
      $display("[TB] FAIL %s: scoreboard empty, got valid=%0b err=%0b", tag, sample_valid, frame_err);
      return;
    end
    e = sbQ.pop_front();
    if (!(sample_valid || frame_err)) begin
      nChecks++;
      $display("[TB] FAIL %s: no output within 4 cycles, expected err=%0b", tag, e.err);
      return;
    end
    checkVal({tag, " frame_err"}, 64'(frame_err), 64'(e.err));
    checkVal({tag, " sample_valid"}, 64'(sample_valid), 64'(!e.err));
    checkVal({tag, " samples"}, 64'(samples), 64'(e.samples));
    checkVal({tag, " led_out"}, 64'(led_out), 64'(e.led));
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " samples"}, 64'(samples), 64'd0);
    checkVal({tag, " sample_valid"}, 64'(sample_valid), 64'd0);
    checkVal({tag, " frame_err"}, 64'(frame_err), 64'd0);
    checkVal({tag, " cal_busy"}, 64'(cal_busy), 64'd0);
    checkVal({tag, " cal_done"}, 64'(cal_done), 64'd0);
    checkVal({tag, " overrun_cnt"}, 64'(overrun_cnt), 64'd0);
    checkVal({tag, " led_out"}, 64'(led_out), 64'd0);
  endtask

  initial begin
    logic [15:0] a0, a1, a2;
    logic [47:0] exp48;

    // n, bytes (first byte leftmost), last byte with frame_end, err, samples, led
    vecs[0] = '{6, 64'h0102_8000_7FFF_0000, 1'b0, 1'b0, 48'h7FFF_8000_0102, 8'h01};
    vecs[1] = '{5, 64'h1111_2222_3300_0000, 1'b0, 1'b1, 48'h7FFF_8000_0102, 8'h01};
    vecs[2] = '{7, 64'h0A0B_0C0D_0E0F_1000, 1'b0, 1'b1, 48'h7FFF_8000_0102, 8'h01};
    vecs[3] = '{6, 64'hABCD_1234_5678_0000, 1'b1, 1'b0, 48'h5678_1234_ABCD, 8'hAB};
    vecs[4] = '{0, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 48'h5678_1234_ABCD, 8'hAB};
    vecs[5] = '{6, 64'h1122_3344_5566_0000, 1'b1, 1'b0, 48'h5566_3344_1122, 8'h11};
    vecs[6] = '{7, 64'hDEAD_BEEF_CAFE_0100, 1'b1, 1'b1, 48'h5566_3344_1122, 8'h11};
    vecs[7] = '{1, 64'h5500_0000_0000_0000, 1'b1, 1'b1, 48'h5566_3344_1122, 8'h11};
    vecs[8] = '{8, 64'h0102_0304_0506_0708, 1'b0, 1'b1, 48'h5566_3344_1122, 8'h11};

    // Reset state
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b1;
    sample_ready = 1'b1;
    @(negedge clk);

    // Frame assembly and length checking
    foreach (vecs[r]) begin
      expectFrame(vecs[r].err, vecs[r].samples);
      applyStimulus(vecs[r].n, vecs[r].data, vecs[r].withEnd, 1'b0);
      checkOutput($sformatf("vec%0d", r));
    end
    checkVal("table overrun_cnt", 64'(overrun_cnt), 64'd0);

    // Overrun: three frames while the consumer is stalled
    sample_ready = 1'b0;
    expectFrame(1'b0, 48'h3333_2222_1111);
    applyStimulus(6, makeFrame(16'h1111, 16'h2222, 16'h3333), 1'b0, 1'b0);
    checkOutput("ovr f1");
    checkVal("ovr f1 overrun_cnt", 64'(overrun_cnt), 64'd0);
    expectFrame(1'b0, 48'h6666_5555_4444);
    applyStimulus(6, makeFrame(16'h4444, 16'h5555, 16'h6666), 1'b0, 1'b0);
    checkOutput("ovr f2");
    expectFrame(1'b0, 48'h9999_8888_7777);
    applyStimulus(6, makeFrame(16'h7777, 16'h8888, 16'h9999), 1'b0, 1'b0);
    checkOutput("ovr f3");
    checkVal("ovr f3 overrun_cnt", 64'(overrun_cnt), 64'd2);
    @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    checkVal("accept drops valid", 64'(sample_valid), 64'd0);

    // Accept and load on the same edge: stays valid, no overrun
    expectFrame(1'b0, 48'h0003_0002_0001);
    applyStimulus(6, makeFrame(16'h0001, 16'h0002, 16'h0003), 1'b0, 1'b0);
    checkOutput("simul f4");
    expectFrame(1'b0, 48'h0006_0005_0004);
    applyStimulus(6, makeFrame(16'h0004, 16'h0005, 16'h0006), 1'b0, 1'b1);
    checkOutput("simul f5");
    checkVal("simul overrun_cnt", 64'(overrun_cnt), 64'd2);

    // Overrun counter saturation
    for (int i = 0; i < 260; i++) begin
      applyStimulus(6, makeFrame(16'(i), 16'h0000, 16'h0000), 1'b0, 1'b0);
    end
    checkVal("overrun saturates", 64'(overrun_cnt), 64'd255);
    sample_ready = 1'b1;
    @(negedge clk);
    checkVal("drain valid", 64'(sample_valid), 64'd0);

    // Calibration: 16 good frames, one bad frame and a stray cal_start inside
    for (int k = 0; k < 3; k++) accModel[k] = 0;
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    checkVal("cal_busy after start", 64'(cal_busy), 64'd1);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        applyStimulus(5, makeFrame(16'h0010, 16'hFFF0, 16'h0000), 1'b0, 1'b0);
        checkVal("cal bad frame_err", 64'(frame_err), 64'd1);
      end
      if (i == 8) begin
        @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
      end
      a2 = 16'(i * 2);
      applyStimulus(6, makeFrame(16'h0010, 16'hFFF0, a2), 1'b0, 1'b0);
      accModel[0] += 16;
      accModel[1] += -16;
      accModel[2] += i * 2;
      if (i == 0) checkVal("cal no sample_valid", 64'(sample_valid), 64'd0);
      if (i == 14) begin
        checkVal("cal_done before 16th", 64'(cal_done), 64'd0);
        checkVal("cal_busy before 16th", 64'(cal_busy), 64'd1);
      end
    end
    checkVal("cal_done pulse", 64'(cal_done), 64'd1);
    checkVal("cal_busy cleared", 64'(cal_busy), 64'd0);
    for (int k = 0; k < 3; k++) offModel[k] = accModel[k] >>> 4;
    @(negedge clk);
    checkVal("cal_done single cycle", 64'(cal_done), 64'd0);

    a0 = 16'h0015; a1 = 16'h0000; a2 = 16'h0000;
    exp48 = {corrModel(a2, offModel[2]), corrModel(a1, offModel[1]), corrModel(a0, offModel[0])};
    expectFrame(1'b0, exp48);
    applyStimulus(6, makeFrame(a0, a1, a2), 1'b0, 1'b0);
    checkOutput("post-cal 0x15");
    checkVal("post-cal axis0", 64'(samples[15:0]), 64'h0005);

    a0 = 16'h8000; a1 = 16'h7FFF; a2 = 16'h0000;
    exp48 = {corrModel(a2, offModel[2]), corrModel(a1, offModel[1]), corrModel(a0, offModel[0])};
    expectFrame(1'b0, exp48);
    applyStimulus(6, makeFrame(a0, a1, a2), 1'b0, 1'b0);
    checkOutput("post-cal saturate");
    checkVal("saturated axis0", 64'(samples[15:0]), 64'h8000);

    // Reset in the middle of a calibration and in the middle of a frame
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6, makeFrame(16'h0100, 16'h0200, 16'h0300), 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'h40 + 8'(i);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    #2 reset = 1'b0;
    #1 checkAllZero("mid reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    expectFrame(1'b1, 48'h0);
    applyStimulus(3, makeFrame(16'h0506, 16'h0700, 16'h0000), 1'b0, 1'b0);
    checkOutput("after reset short");
    for (int k = 0; k < 3; k++) offModel[k] = 0;
    a0 = 16'h0015; a1 = 16'h8000; a2 = 16'h7FFF;
    exp48 = {corrModel(a2, offModel[2]), corrModel(a1, offModel[1]), corrModel(a0, offModel[0])};
    expectFrame(1'b0, exp48);
    applyStimulus(6, makeFrame(a0, a1, a2), 1'b0, 1'b0);
    checkOutput("after reset good");
    checkVal("after reset overrun_cnt", 64'(overrun_cnt), 64'd0);
    checkVal("after reset cal_busy", 64'(cal_busy), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
